// File: rtl/regfile_stream_reader_pkg.sv
// Shared definitions for the register-file stream reader: state encoding and
// the width defaults it shares with the 16x16 register file.
package regfile_stream_reader_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_e;

endpackage

// File: rtl/regfile_stream_reader_if.sv
// Command, register-file read port and output stream of the stream reader.
// master = the reader, slave = the surrounding command/regfile/sink logic.
interface regfile_stream_reader_if #(
    parameter int DATA_W = regfile_stream_reader_pkg::DATA_W_DEF,
    parameter int ADDR_W = regfile_stream_reader_pkg::ADDR_W_DEF
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] count;
    logic              busy;
    logic              done;

    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        input  start, start_addr, count, rf_data, out_ready,
        output busy, done, rf_addr, out_valid, out_data, out_last
    );

    modport slave (
        output start, start_addr, count, rf_data, out_ready,
        input  busy, done, rf_addr, out_valid, out_data, out_last
    );
endinterface

// File: rtl/regfile_stream_reader.sv
// Walks a wrapping range of register-file addresses through the asynchronous
// read port and emits each word on a valid/ready stream with a last marker.
module regfile_stream_reader #(
    parameter int DATA_W = regfile_stream_reader_pkg::DATA_W_DEF,
    parameter int ADDR_W = regfile_stream_reader_pkg::ADDR_W_DEF
) (
    input logic                     clk,
    input logic                     rst,
    regfile_stream_reader_if.master bus
);
    import regfile_stream_reader_pkg::*;

    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    // A count of zero stands for a full sweep of the register file.
    function automatic logic [ADDR_W:0] decode_count(input logic [ADDR_W-1:0] cnt);
        if (cnt == PTR_ZERO) begin
            return {1'b1, {ADDR_W{1'b0}}};
        end else begin
            return {1'b0, cnt};
        end
    endfunction

    state_e            state_r, state_next_s;
    logic [ADDR_W-1:0] ptr_r, ptr_next_s;
    logic [ADDR_W:0]   remaining_r, remaining_next_s;
    logic [DATA_W-1:0] data_r, data_next_s;
    logic              valid_r, valid_next_s;
    logic              last_r, last_next_s;
    logic              done_r, done_next_s;
    logic              busy_r;
    logic              capture_s;

    // Next-state and datapath decode; a capture loads the word at ptr and advances.
    always_comb begin
        state_next_s     = state_r;
        ptr_next_s       = ptr_r;
        remaining_next_s = remaining_r;
        data_next_s      = data_r;
        valid_next_s     = valid_r;
        last_next_s      = last_r;
        done_next_s      = 1'b0;
        capture_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    ptr_next_s       = bus.start_addr;
                    remaining_next_s = decode_count(bus.count);
                    state_next_s     = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                capture_s    = 1'b1;
                state_next_s = ST_SEND;
            end
            ST_SEND: begin
                if (valid_r && bus.out_ready) begin
                    if (last_r) begin
                        valid_next_s = 1'b0;
                        last_next_s  = 1'b0;
                        done_next_s  = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        capture_s = 1'b1;
                    end
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            default: begin
                valid_next_s = 1'b0;
                last_next_s  = 1'b0;
                state_next_s = ST_IDLE;
            end
        endcase

        // Capture stops at remaining==1, so the decrement cannot underflow.
        if (capture_s) begin
            data_next_s      = bus.rf_data;
            valid_next_s     = 1'b1;
            last_next_s      = (remaining_r == REM_ONE);
            ptr_next_s       = ptr_r + PTR_ONE;
            remaining_next_s = remaining_r - REM_ONE;
        end else begin
            data_next_s = data_next_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= PTR_ZERO;
            remaining_r <= {(ADDR_W+1){1'b0}};
            data_r      <= DATA_ZERO;
            valid_r     <= 1'b0;
            last_r      <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            ptr_r       <= ptr_next_s;
            remaining_r <= remaining_next_s;
            data_r      <= data_next_s;
            valid_r     <= valid_next_s;
            last_r      <= last_next_s;
            done_r      <= done_next_s;
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    assign bus.rf_addr   = ptr_r;
    assign bus.out_data  = data_r;
    assign bus.out_valid = valid_r;
    assign bus.out_last  = last_r;
    assign bus.done      = done_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_regfile_stream_reader.sv
// Directed bench for regfile_stream_reader paired with a behavioural 16x16
// register file (async read, one synchronous write port).
module tb_regfile_stream_reader;

    logic clk;
    logic rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] rf [16];

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] got_data[$];
    logic        got_last[$];
    logic [3:0]  got_addr[$];

    regfile_stream_reader_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    regfile_stream_reader #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) rf[wr_addr] <= wr_data;
    end

    assign bus.rf_data = rf[bus.rf_addr];

    typedef struct {
        logic [3:0]  sa;
        logic [3:0]  cnt;
        logic [15:0] rdy_pat;
        int          rdy_len;
        int          exp_words;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
        int          exp_done;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // Issues one command and collects handshaken words; done_cyc counts edges
    // from the edge before start was raised.
    task automatic run_xfer(input logic [3:0] sa, input logic [3:0] cnt,
                            input logic [15:0] pat, input int plen, output int done_cyc);
        int c;
        int vc;
        bit hold;
        bit fin;
        logic [15:0] hd;
        logic hl;
        got_data.delete(); got_last.delete(); got_addr.delete();
        done_cyc = -1; vc = 0; hold = 1'b0; fin = 1'b0; hd = 16'h0000; hl = 1'b0;
        bus.start = 1'b1; bus.start_addr = sa; bus.count = cnt; bus.out_ready = 1'b0;
        step();
        bus.start = 1'b0;
        c = 1;
        while (!fin && c < 200) begin
            bus.out_ready = bus.out_valid ? pat[vc % plen] : 1'b0;
            @(negedge clk);
            if (hold) begin
                check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                check("hold_data", {16'd0, bus.out_data}, {16'd0, hd});
                check("hold_last", {31'd0, bus.out_last}, {31'd0, hl});
                hold = 1'b0;
            end
            if (c == 1) begin
                check("busy_fetch", {31'd0, bus.busy}, 32'd1);
                got_addr.push_back(bus.rf_addr);
            end
            if (bus.done) begin
                done_cyc = c;
                check("busy_at_done", {31'd0, bus.busy}, 32'd0);
                check("valid_at_done", {31'd0, bus.out_valid}, 32'd0);
                fin = 1'b1;
            end else if (bus.out_valid) begin
                if (bus.out_ready) begin
                    got_data.push_back(bus.out_data);
                    got_last.push_back(bus.out_last);
                    if (!bus.out_last) got_addr.push_back(bus.rf_addr);
                end else begin
                    hold = 1'b1; hd = bus.out_data; hl = bus.out_last;
                end
                vc++;
            end
            step();
            c++;
        end
        bus.out_ready = 1'b0;
        if (!fin) check("done_timeout", 32'd0, 32'd1);
    endtask

    vec_t vecs[5];

    initial begin
        int dc;
        rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'h0000;
        bus.start = 1'b0; bus.start_addr = 4'd0; bus.count = 4'd0; bus.out_ready = 1'b0;

        vecs[0] = '{sa: 4'd0,  cnt: 4'd4, rdy_pat: 16'h0001, rdy_len: 1, exp_words: 4,
                    exp_first: 16'hA000, exp_last: 16'hA003, exp_done: 6};
        vecs[1] = '{sa: 4'd14, cnt: 4'd4, rdy_pat: 16'h0001, rdy_len: 1, exp_words: 4,
                    exp_first: 16'hA00E, exp_last: 16'hA001, exp_done: 6};
        vecs[2] = '{sa: 4'd1,  cnt: 4'd3, rdy_pat: 16'h0029, rdy_len: 6, exp_words: 3,
                    exp_first: 16'hA001, exp_last: 16'hA003, exp_done: 8};
        vecs[3] = '{sa: 4'd5,  cnt: 4'd0, rdy_pat: 16'h0001, rdy_len: 1, exp_words: 16,
                    exp_first: 16'hA005, exp_last: 16'hA004, exp_done: 18};
        vecs[4] = '{sa: 4'd15, cnt: 4'd1, rdy_pat: 16'h0001, rdy_len: 1, exp_words: 1,
                    exp_first: 16'hA00F, exp_last: 16'hA00F, exp_done: 3};

        #1;
        for (int i = 0; i < 16; i++) write_reg(4'(i), 16'hA000 + 16'(i));
        @(negedge clk);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_last", {31'd0, bus.out_last}, 32'd0);
        check("rst_data", {16'd0, bus.out_data}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_rf_addr", {28'd0, bus.rf_addr}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Table-driven transfers.
        for (int v = 0; v < 5; v++) begin
            run_xfer(vecs[v].sa, vecs[v].cnt, vecs[v].rdy_pat, vecs[v].rdy_len, dc);
            check("word_count", got_data.size(), vecs[v].exp_words);
            check("addr_count", got_addr.size(), vecs[v].exp_words);
            check("done_cycle", dc, vecs[v].exp_done);
            if (got_data.size() > 0) begin
                check("first_word", {16'd0, got_data[0]}, {16'd0, vecs[v].exp_first});
                check("final_word", {16'd0, got_data[got_data.size()-1]}, {16'd0, vecs[v].exp_last});
            end
            for (int i = 0; i < got_data.size(); i++) begin
                logic [3:0] ea;
                ea = vecs[v].sa + 4'(i);
                check("word_data", {16'd0, got_data[i]}, {16'd0, 16'hA000 + {12'd0, ea}});
                check("word_last", {31'd0, got_last[i]}, {31'd0, (i == vecs[v].exp_words - 1)});
            end
            for (int i = 0; i < got_addr.size(); i++) begin
                logic [3:0] ea;
                ea = vecs[v].sa + 4'(i);
                check("rf_addr_seq", {28'd0, got_addr[i]}, {28'd0, ea});
            end
            step();
        end

        // Start while busy is ignored; a start in the done cycle is accepted.
        bus.start = 1'b1; bus.start_addr = 4'd8; bus.count = 4'd2; bus.out_ready = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.start = 1'b1; bus.start_addr = 4'd12; bus.count = 4'd5;
        @(negedge clk);
        check("bz_word0", {16'd0, bus.out_data}, 32'h0000A008);
        step();
        @(negedge clk);
        check("bz_word1", {16'd0, bus.out_data}, 32'h0000A009);
        check("bz_last1", {31'd0, bus.out_last}, 32'd1);
        step();
        bus.start = 1'b1; bus.start_addr = 4'd10; bus.count = 4'd1; bus.out_ready = 1'b0;
        @(negedge clk);
        check("bz_done", {31'd0, bus.done}, 32'd1);
        check("bz_busy_low", {31'd0, bus.busy}, 32'd0);
        step();
        bus.start = 1'b0;
        @(negedge clk);
        check("done_cycle_start_busy", {31'd0, bus.busy}, 32'd1);
        step();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("restart_data", {16'd0, bus.out_data}, 32'h0000A00A);
        check("restart_last", {31'd0, bus.out_last}, 32'd1);
        step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("restart_done", {31'd0, bus.done}, 32'd1);
        step();
        @(negedge clk);
        check("no_queued_busy", {31'd0, bus.busy}, 32'd0);
        check("no_queued_valid", {31'd0, bus.out_valid}, 32'd0);
        step();

        // Reset on the second beat of an 8-word transfer.
        bus.start = 1'b1; bus.start_addr = 4'd0; bus.count = 4'd8; bus.out_ready = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check("rst_mid_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_mid_done", {31'd0, bus.done}, 32'd0);
        rst = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            @(negedge clk);
            check("rst_no_done", {30'd0, bus.done, bus.out_valid}, 32'd0);
        end
        step();
        run_xfer(4'd3, 4'd2, 16'h0001, 1, dc);
        check("post_rst_count", got_data.size(), 2);
        check("post_rst_done", dc, 4);
        if (got_data.size() == 2) begin
            check("post_rst_w0", {16'd0, got_data[0]}, 32'h0000A003);
            check("post_rst_w1", {16'd0, got_data[1]}, 32'h0000A004);
        end
        step();

        // Write coherency around the capture edges.
        write_reg(4'd2, 16'h00BB);
        write_reg(4'd3, 16'h0033);
        bus.start = 1'b1; bus.start_addr = 4'd2; bus.count = 4'd2; bus.out_ready = 1'b0;
        step();
        bus.start = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h1234;
        step();
        wr_addr = 4'd3; wr_data = 16'h5678;
        @(negedge clk);
        check("same_edge_old", {16'd0, bus.out_data}, 32'h000000BB);
        check("same_edge_valid", {31'd0, bus.out_valid}, 32'd1);
        step();
        wr_en = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("stall_hold_old", {16'd0, bus.out_data}, 32'h000000BB);
        check("stall_hold_last", {31'd0, bus.out_last}, 32'd0);
        step();
        @(negedge clk);
        check("later_write_seen", {16'd0, bus.out_data}, 32'h00005678);
        check("later_write_last", {31'd0, bus.out_last}, 32'd1);
        step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("coh_done", {31'd0, bus.done}, 32'd1);
        check("coh_valid_low", {31'd0, bus.out_valid}, 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
